psdifir_audio_tx: RTL and testbench

Serial audio transmitter at the output end of the PSDIFIR filter datapath. It consumes the filter's parallel output samples (`left_out`/`right_out` qualified by `dataout_ready`) and emits them as an I2S stream with a self-generated bit clock and word clock. It buffers one stereo pair between the filter's bursty output and the fixed-rate serial frame, and flags overrun/underrun. A `frame_start` strobe is provided so the upstream sequencer can pace `datain_ready` at the frame rate.

---
 rtl/psdifir_audio_tx.sv | 129 ++++++++++++
 tb/tb_psdifir_audio_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psdifir_audio_tx.sv
// I2S transmitter for the PSDIFIR output: one-pair holding buffer, self-timed
// bit/word clocks, 64-bit frames with 1-bit delay and sticky overrun/underrun flags.
module psdifir_audio_tx #(
    parameter int BCLK_DIV = 16,
    parameter int DATA_W   = 18
) (
    input  logic                     clockext100MHz,
    input  logic                     reset_n,
    input  logic                     dataout_ready,
    input  logic signed [DATA_W-1:0] left_out,
    input  logic signed [DATA_W-1:0] right_out,
    input  logic                     err_clr,
    output logic                     i2s_bclk,
    output logic                     i2s_lrclk,
    output logic                     i2s_sdata,
    output logic                     frame_start,
    output logic                     overrun,
    output logic                     underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]         div_cnt;
    logic [5:0]               bit_cnt;
    logic [5:0]               bit_next;
    logic                     tick;
    logic                     fall;
    logic                     load;
    logic signed [DATA_W-1:0] hold_l;
    logic signed [DATA_W-1:0] hold_r;
    logic                     hold_valid;
    logic signed [DATA_W-1:0] src_l;
    logic signed [DATA_W-1:0] src_r;
    logic                     ovr_set;
    logic                     und_set;

    // Slot position 0 is the I2S one-bit delay; MSB sits at position 1.
    function automatic logic slot_bit(input logic [DATA_W-1:0] smp, input logic [4:0] pos);
        logic [IDX_W-1:0] idx;
        slot_bit = 1'b0;
        idx      = '0;
        if (pos != 5'd0 && int'(pos) <= DATA_W) begin
            idx      = IDX_W'(DATA_W - int'(pos));
            slot_bit = smp[idx];
        end
    endfunction

    assign tick     = (div_cnt == DIV_LAST);
    assign fall     = tick && i2s_bclk;
    assign bit_next = bit_cnt + 6'd1;
    assign load     = fall && (bit_next == 6'd0);
    assign ovr_set  = dataout_ready && hold_valid && !load;
    assign und_set  = load && !hold_valid;

    // Bit-clock divider and frame bit position
    always_ff @(posedge clockext100MHz or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            i2s_bclk <= 1'b0;
            bit_cnt  <= 6'd63;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                i2s_bclk <= ~i2s_bclk;
            end
            if (fall) begin
                bit_cnt <= bit_next;
            end
        end
    end

    // Holding register: data path carries no reset, only its valid flag does
    always_ff @(posedge clockext100MHz) begin
        if (dataout_ready) begin
            hold_l <= left_out;
            hold_r <= right_out;
        end
    end

    always_ff @(posedge clockext100MHz or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
        end else if (dataout_ready) begin
            hold_valid <= 1'b1;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    // Shift source keeps the previous pair when nothing new is waiting
    always_ff @(posedge clockext100MHz or negedge reset_n) begin
        if (!reset_n) begin
            src_l <= '0;
            src_r <= '0;
        end else if (load && hold_valid) begin
            src_l <= hold_l;
            src_r <= hold_r;
        end
    end

    // Serial outputs move together with the falling bclk edge
    always_ff @(posedge clockext100MHz or negedge reset_n) begin
        if (!reset_n) begin
            i2s_lrclk   <= 1'b0;
            i2s_sdata   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= load;
            if (fall) begin
                i2s_lrclk <= bit_next[5];
                i2s_sdata <= slot_bit(bit_next[5] ? src_r : src_l, bit_next[4:0]);
            end
        end
    end

    // Sticky flags: a fresh event outranks a simultaneous clear
    always_ff @(posedge clockext100MHz or negedge reset_n) begin
        if (!reset_n) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overrun  <= (overrun && !err_clr) || ovr_set;
            underrun <= (underrun && !err_clr) || und_set;
        end
    end

endmodule

// File: tb/tb_psdifir_audio_tx.sv
// Directed bench for psdifir_audio_tx: decodes frames on bclk rising edges and
// compares against hand-built I2S frames (BCLK_DIV = 2 and default 16).
module tb_psdifir_audio_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst2_n, rst16_n;
    logic        dr2, dr16, clr2, clr16;
    logic [17:0] l2, r2, l16, r16;
    logic        bclk2, lrclk2, sdata2, fs2, ovr2, und2;
    logic        bclk16, lrclk16, sdata16, fs16, ovr16, und16;
    logic        sel;
    logic        bclk_m, lrclk_m, sdata_m, fs_m;

    assign bclk_m  = sel ? bclk16  : bclk2;
    assign lrclk_m = sel ? lrclk16 : lrclk2;
    assign sdata_m = sel ? sdata16 : sdata2;
    assign fs_m    = sel ? fs16    : fs2;

    psdifir_audio_tx #(.BCLK_DIV(2)) dut (
        .clockext100MHz(clk),
        .reset_n       (rst2_n),
        .dataout_ready (dr2),
        .left_out      (l2),
        .right_out     (r2),
        .err_clr       (clr2),
        .i2s_bclk      (bclk2),
        .i2s_lrclk     (lrclk2),
        .i2s_sdata     (sdata2),
        .frame_start   (fs2),
        .overrun       (ovr2),
        .underrun      (und2)
    );

    psdifir_audio_tx #(.BCLK_DIV(16)) dut16 (
        .clockext100MHz(clk),
        .reset_n       (rst16_n),
        .dataout_ready (dr16),
        .left_out      (l16),
        .right_out     (r16),
        .err_clr       (clr16),
        .i2s_bclk      (bclk16),
        .i2s_lrclk     (lrclk16),
        .i2s_sdata     (sdata16),
        .frame_start   (fs16),
        .overrun       (ovr16),
        .underrun      (und16)
    );

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmit order: element 0 of the frame is bit 63 of the vector.
    function automatic logic [63:0] build_frame(input logic [17:0] l, input logic [17:0] r);
        return {1'b0, l, 13'b0, 1'b0, r, 13'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [17:0] l, input logic [17:0] r);
        if (sel) begin
            dr16 = 1'b1; l16 = l; r16 = r;
        end else begin
            dr2 = 1'b1; l2 = l; r2 = r;
        end
        tick();
        dr2  = 1'b0;
        dr16 = 1'b0;
    endtask

    task automatic pulse_clr();
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
    endtask

    task automatic wait_frame_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (fs_m) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("frame_start_timeout", 64'd0, 64'd1);
    endtask

    task automatic next_bclk_rise(output bit ok);
        logic prev;
        prev = bclk_m;
        ok   = 1'b0;
        for (int j = 0; j < 200; j++) begin
            tick();
            if (bclk_m && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = bclk_m;
        end
        if (!ok) check_eq("bclk_timeout", 64'd0, 64'd1);
    endtask

    task automatic capture(input bit wait_start, output logic [63:0] data, output logic [63:0] lr);
        bit ok;
        data = '0;
        lr   = '0;
        if (wait_start) begin
            wait_frame_start(ok);
            if (!ok) return;
        end
        for (int i = 0; i < 64; i++) begin
            next_bclk_rise(ok);
            if (!ok) return;
            data[63-i] = sdata_m;
            lr[63-i]   = lrclk_m;
        end
    endtask

    task automatic measure_release(input string tag, input int exp_n);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            n++;
            if (fs_m) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq(tag, 64'(hit ? n : -1), 64'(exp_n));
    endtask

    initial begin
        logic [63:0] d, lr;
        bit          ok;
        int          n0, c1, c2;

        sel = 1'b0;
        rst2_n = 1'b0; rst16_n = 1'b0;
        dr2 = 1'b0; dr16 = 1'b0; clr2 = 1'b0; clr16 = 1'b0;
        l2 = '0; r2 = '0; l16 = '0; r16 = '0;

        repeat (5) tick();
        check_eq("reset_outputs", {bclk2, lrclk2, sdata2, fs2, ovr2, und2}, 64'd0);
        @(negedge clk) rst2_n = 1'b1;
        measure_release("first_frame_start_clk", 4);
        check_eq("underrun_after_reset", und2, 1);
        check_eq("overrun_after_reset", ovr2, 0);

        // Single pair
        repeat (10) tick();
        strobe(18'h2AAAA, 18'h15555);
        pulse_clr();
        check_eq("underrun_cleared", und2, 0);
        capture(1'b1, d, lr);
        check_eq("single_frame", d, build_frame(18'h2AAAA, 18'h15555));
        check_eq("single_left_word", d[62:45], 18'b10_1010_1010_1010_1010);
        check_eq("single_right_word", d[30:13], 18'b01_0101_0101_0101_0101);
        check_eq("single_lrclk", lr, LR_EXP);
        check_eq("no_underrun_loaded", und2, 0);

        // Underrun: no strobe for a frame
        capture(1'b1, d, lr);
        check_eq("underrun_repeat", d, build_frame(18'h2AAAA, 18'h15555));
        check_eq("underrun_set", und2, 1);

        // Overrun: two strobes 3 clocks apart
        wait_frame_start(ok);
        pulse_clr();
        check_eq("underrun_clr2", und2, 0);
        repeat (5) tick();
        strobe(18'h30001, 18'h0FFFE);
        repeat (2) tick();
        strobe(18'h12345, 18'h20F0F);
        check_eq("overrun_set", ovr2, 1);
        pulse_clr();
        check_eq("overrun_clr", ovr2, 0);
        capture(1'b1, d, lr);
        check_eq("overrun_second_pair", d, build_frame(18'h12345, 18'h20F0F));
        check_eq("flags_after_overrun", {ovr2, und2}, 64'd0);

        // Strobe coincident with a frame load while the holding register is empty
        wait_frame_start(ok);
        n0 = cyc;
        pulse_clr();
        check_eq("underrun_clr3", und2, 0);
        while (cyc < n0 + 255) tick();
        strobe(18'h0ABCD, 18'h3C3C3);
        check_eq("coincident_frame_start", fs2, 1);
        check_eq("coincident_underrun", und2, 1);
        check_eq("coincident_no_overrun", ovr2, 0);
        capture(1'b0, d, lr);
        check_eq("coincident_old_pair", d, build_frame(18'h12345, 18'h20F0F));
        capture(1'b1, d, lr);
        check_eq("coincident_new_pair", d, build_frame(18'h0ABCD, 18'h3C3C3));
        check_eq("coincident_overrun_late", ovr2, 0);

        // Reset mid-frame with a pair waiting
        wait_frame_start(ok);
        repeat (20) tick();
        strobe(18'h1F00F, 18'h00FF0);
        repeat (10) tick();
        @(negedge clk) rst2_n = 1'b0;
        #1;
        check_eq("midreset_outputs", {bclk2, lrclk2, sdata2, fs2, ovr2, und2}, 64'd0);
        repeat (3) tick();
        @(negedge clk) rst2_n = 1'b1;
        measure_release("midreset_frame_start_clk", 4);
        check_eq("midreset_underrun", und2, 1);
        capture(1'b0, d, lr);
        check_eq("midreset_pair_discarded", d, 64'd0);

        // Negative full scale at the default divider
        sel = 1'b1;
        @(negedge clk) rst16_n = 1'b1;
        measure_release("div16_first_frame_start", 32);
        repeat (5) tick();
        strobe(18'h20000, 18'h1FFFF);
        capture(1'b1, d, lr);
        check_eq("div16_frame", d, build_frame(18'h20000, 18'h1FFFF));
        check_eq("div16_left_word", d[62:45], 18'h20000);
        check_eq("div16_lrclk", lr, LR_EXP);
        wait_frame_start(ok);
        c1 = cyc;
        wait_frame_start(ok);
        c2 = cyc;
        check_eq("div16_frame_period", 64'(c2 - c1), 64'd2048);
        next_bclk_rise(ok);
        c1 = cyc;
        next_bclk_rise(ok);
        c2 = cyc;
        check_eq("div16_bclk_period", 64'(c2 - c1), 64'd32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
